rx_port_pkt_arbiter: RTL and testbench
======================================

Name: rx_port_pkt_arbiter

Overview:
- Packet-granular round-robin arbiter in the system clock domain.
- Merges up to 4 per-port receive queues into one 128-bit packet stream for the switching core.
- Each port queue is a stat FIFO plus a data FIFO. Both are first-word-fall-through, with 96-bit {valid, len[14:0], id[15:0], time[63:0]} stat entries and 128-bit left-justified payload lines.
- Packets whose stat valid bit is 0, or whose length is 0, are drained from the data FIFO and counted, never forwarded.

Parameters:
- PORT_NUM, 4, number of requesting ports (2..4).
- PORT_W, 2, width of port index.
- DROP_CNT_W, 32, width of the drop counter.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- stat_empty  in  PORT_NUM  per-port stat FIFO empty.
- stat_rdata  in  96*PORT_NUM  per-port stat head; port i occupies bits [96*i+95:96*i].
- stat_rd  out  PORT_NUM  stat pop, one pulse per packet.
- data_empty  in  PORT_NUM  per-port data FIFO empty.
- data_rdata  in  128*PORT_NUM  per-port data head; port i occupies bits [128*i+127:128*i].
- data_rd  out  PORT_NUM  data pop.
- out_valid  out  1  output line valid (registered).
- out_data  out  128  output line.
- out_sop  out  1  first line of packet.
- out_eop  out  1  last line of packet.
- out_port  out  PORT_W  source port.
- out_len  out  15  packet byte length; valid with out_sop.
- out_time  out  64  packet timestamp; valid with out_sop.
- out_ready  in  1  downstream accept.
- drop_cnt  out  DROP_CNT_W  count of dropped packets, saturating.

Behaviour:
- Reset:
  - The design has one clock; reset is asynchronous and active-low, named sys_clk/sys_rst_n.
  - On reset, every output is 0. The state machine goes to IDLE and the round-robin pointer rr_last goes to PORT_NUM-1.
  - Reset mid-packet abandons the packet. FIFO resynchronisation is the wrapper's job.
- States: IDLE, SEND, DROP.
- IDLE:
  - Requesters are ports with stat_empty=0. The grant is the first requester searching from rr_last+1 upward, with modulo wrap.
  - In the grant cycle:
    - stat_rd[g]=1 for exactly 1 cycle.
    - Latch gnt=g, len and time.
    - lines_left = (len+15)>>4, 12-bit. The maximum is 2048 for len=32767.
    - rr_last<=g.
  - Next state: if valid=1 and len!=0, go to SEND; else go to DROP. For len=0, lines_left=0, DROP pops nothing and returns to IDLE next cycle.
  - With no requesters, stay in IDLE.
- Output register:
  - load = ~out_valid | out_ready.
  - In SEND, data_rd[gnt] = load & ~data_empty[gnt].
  - A pop loads out_data, sets out_valid=1, and sets out_sop for the first line and out_eop when lines_left==1.
  - out_port/out_len/out_time are held for the whole packet.
  - When load=1 and no pop occurs, out_valid goes to 0.
- Lines: lines_left decrements per pop. After the last pop the state returns to IDLE, so the next grant can happen while the eop line waits in the output register.
- Back-to-back: minimum 1 IDLE cycle between packets. Throughput is 1 line/cycle within a packet when out_ready=1 and the data FIFO is non-empty.
- Data underrun (data_empty during SEND): stall without a bubble error; out_valid drops.
- DROP:
  - data_rd[gnt] = ~data_empty[gnt], decrementing lines_left. Nothing is driven on the out_* bus.
  - When lines_left reaches 0, drop_cnt increments (saturating at all ones) and the state returns to IDLE.
  - Drop does not depend on out_ready.
- Only one bit of stat_rd|data_rd is ever set at a time. No pop ever targets an empty FIFO.

Optional Feature:
- RX_ARB_STRICT_PRIO_EN defined: IDLE grants the lowest-index requester (port 0 highest). rr_last is not used.
- Undefined: round-robin as above.
- DROP handling and timing are identical in both modes.

Test Plan:
- Single packet, port 1, len=40, valid=1, out_ready=1:
  - 1 stat_rd.
  - 3 lines out with sop on line 1, eop on line 3.
  - out_port=1, out_len=40.
  - drop_cnt=0.
- All 4 ports hold one 16-byte packet each, rr_last=3 after reset: output order is ports 0,1,2,3, each a single line with sop=eop=1.
- Port 2 stat valid=0, len=100: 7 data pops, no out_valid, drop_cnt=1, then the next port is serviced.
- out_ready toggling 1/0 on a len=64 packet: no line is lost or duplicated; out_data holds while out_valid&~out_ready; 4 lines total.
- Port 0 len=0, valid=1: stat popped, 0 data pops, drop_cnt increments, returns to IDLE in 2 cycles.
- sys_rst_n asserted mid-SEND at line 2 of 5: all outputs 0 immediately; after release, IDLE with rr_last=PORT_NUM-1.

Source files
------------

// File: rtl/rx_port_pkt_arbiter.sv
// Packet-granular arbiter merging per-port stat/data FWFT queues into one 128-bit stream.
// Define RX_ARB_STRICT_PRIO_EN for fixed priority (port 0 highest); round-robin otherwise.
module rx_port_pkt_arbiter #(
  parameter int PORT_NUM   = 4,
  parameter int PORT_W     = 2,
  parameter int DROP_CNT_W = 32
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic [PORT_NUM-1:0]     stat_empty,
  input  logic [96*PORT_NUM-1:0]  stat_rdata,
  output logic [PORT_NUM-1:0]     stat_rd,
  input  logic [PORT_NUM-1:0]     data_empty,
  input  logic [128*PORT_NUM-1:0] data_rdata,
  output logic [PORT_NUM-1:0]     data_rd,
  output logic                    out_valid,
  output logic [127:0]            out_data,
  output logic                    out_sop,
  output logic                    out_eop,
  output logic [PORT_W-1:0]       out_port,
  output logic [14:0]             out_len,
  output logic [63:0]             out_time,
  input  logic                    out_ready,
  output logic [DROP_CNT_W-1:0]   drop_cnt,
  output logic [1:0]              dbg_state
);

  // valid/ready: a line moves downstream on a clock edge where out_valid and out_ready
  // are both 1; out_valid never drops and out_data never changes while the line is unaccepted.

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, DROP = 2'd2} state_t;

  state_t              state, state_nxt;
  logic [PORT_W-1:0]   rr_last, gnt, pick;
  logic                pick_vld;
  logic [95:0]         stat_arr [PORT_NUM];
  logic [127:0]        data_arr [PORT_NUM];
  logic [95:0]         pick_stat;
  logic                pick_valid;
  logic [14:0]         pick_len;
  logic [63:0]         pick_time;
  logic [15:0]         len_sum;
  logic [11:0]         pick_lines;
  logic [14:0]         len_q;
  logic [63:0]         time_q;
  logic [11:0]         lines_left;
  logic                first_q;
  logic                load, pop, drop_done;
  logic                unused_stat;

  for (genvar i = 0; i < PORT_NUM; i++) begin : g_split
    assign stat_arr[i] = stat_rdata[96*i +: 96];
    assign data_arr[i] = data_rdata[128*i +: 128];
  end

  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    // Reverse scan so the earliest candidate in priority order wins.
`ifdef RX_ARB_STRICT_PRIO_EN
    for (int i = PORT_NUM - 1; i >= 0; i--) begin
      if (!stat_empty[i]) begin
        pick     = PORT_W'(i);
        pick_vld = 1'b1;
      end
    end
`else
    for (int i = PORT_NUM; i >= 1; i--) begin
      if (!stat_empty[(int'(rr_last) + i) % PORT_NUM]) begin
        pick     = PORT_W'((int'(rr_last) + i) % PORT_NUM);
        pick_vld = 1'b1;
      end
    end
`endif
  end

`ifdef RX_ARB_STRICT_PRIO_EN
  logic unused_rr;
  assign unused_rr = ^rr_last;
`endif

  assign pick_stat   = stat_arr[pick];
  assign pick_valid  = pick_stat[95];
  assign pick_len    = pick_stat[94:80];
  assign pick_time   = pick_stat[63:0];
  assign unused_stat = ^pick_stat[79:64];
  assign len_sum     = {1'b0, pick_len} + 16'd15;
  assign pick_lines  = len_sum[15:4];

  assign load      = ~out_valid | out_ready;
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    stat_rd   = '0;
    data_rd   = '0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          stat_rd[pick] = 1'b1;
          state_nxt     = (pick_valid && pick_len != 15'd0) ? SEND : DROP;
        end
      end
      SEND: begin
        if (load && !data_empty[gnt]) begin
          data_rd[gnt] = 1'b1;
          pop          = 1'b1;
          if (lines_left == 12'd1) state_nxt = IDLE;
        end
      end
      DROP: begin
        if (lines_left == 12'd0) begin
          state_nxt = IDLE;
        end else if (!data_empty[gnt]) begin
          data_rd[gnt] = 1'b1;
          if (lines_left == 12'd1) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Pops are combinational, so hold them off while reset is asserted.
    if (!sys_rst_n) begin
      stat_rd = '0;
      data_rd = '0;
    end
  end

  assign drop_done = (state == DROP) && (state_nxt == IDLE);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      rr_last    <= PORT_W'(PORT_NUM - 1);
      gnt        <= '0;
      len_q      <= '0;
      time_q     <= '0;
      lines_left <= '0;
      first_q    <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      out_port   <= '0;
      out_len    <= '0;
      out_time   <= '0;
      drop_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && pick_vld) begin
        gnt        <= pick;
        len_q      <= pick_len;
        time_q     <= pick_time;
        lines_left <= pick_lines;
        first_q    <= 1'b1;
        rr_last    <= pick;
      end else if (data_rd != '0) begin
        lines_left <= lines_left - 12'd1;
      end
      if (pop) begin
        out_valid <= 1'b1;
        out_data  <= data_arr[gnt];
        out_sop   <= first_q;
        out_eop   <= (lines_left == 12'd1);
        out_port  <= gnt;
        out_len   <= len_q;
        out_time  <= time_q;
        first_q   <= 1'b0;
      end else if (load) begin
        out_valid <= 1'b0;
        out_sop   <= 1'b0;
        out_eop   <= 1'b0;
      end
      if (drop_done && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_rx_port_pkt_arbiter.sv
// Directed bench for rx_port_pkt_arbiter: FWFT queue models, output monitor, per-scenario tasks.
module tb_rx_port_pkt_arbiter;
  localparam int PN = 4;
  localparam int W  = 211;  // {sop, eop, port[1:0], len[14:0], time[63:0], data[127:0]}

  logic              sys_clk = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic [PN-1:0]     stat_empty, data_empty, stat_rd, data_rd;
  logic [96*PN-1:0]  stat_rdata;
  logic [128*PN-1:0] data_rdata;
  logic              out_valid, out_sop, out_eop, out_ready;
  logic [127:0]      out_data;
  logic [1:0]        out_port, dbg_state;
  logic [14:0]       out_len;
  logic [63:0]       out_time;
  logic [31:0]       drop_cnt;

  logic [95:0]  sq [PN][$];
  logic [127:0] dq [PN][$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int stat_pops, data_pops, ready_mode;
  logic [PN-1:0] stat_pop_s, data_pop_s;
  logic prev_hold;
  logic [127:0] prev_data;

  rx_port_pkt_arbiter dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .stat_empty(stat_empty), .stat_rdata(stat_rdata), .stat_rd(stat_rd),
    .data_empty(data_empty), .data_rdata(data_rdata), .data_rd(data_rd),
    .out_valid(out_valid), .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
    .out_port(out_port), .out_len(out_len), .out_time(out_time), .out_ready(out_ready),
    .drop_cnt(drop_cnt), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 sys_clk = ~sys_clk;

  // ---------------- queue models / drivers ----------------
  task automatic refresh();
    for (int i = 0; i < PN; i++) begin
      stat_empty[i] = (sq[i].size() == 0);
      stat_rdata[96*i +: 96] = (sq[i].size() != 0) ? sq[i][0] : 96'd0;
      data_empty[i] = (dq[i].size() == 0);
      data_rdata[128*i +: 128] = (dq[i].size() != 0) ? dq[i][0] : 128'd0;
    end
  endtask

  function automatic bit all_empty();
    bit e = 1'b1;
    for (int i = 0; i < PN; i++) if (sq[i].size() != 0 || dq[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic clear_all();
    for (int i = 0; i < PN; i++) begin
      sq[i].delete();
      dq[i].delete();
    end
    exp_q.delete();
    obs_q.delete();
    refresh();
  endtask

  task automatic push_pkt(input int port, input logic vld, input logic [14:0] len,
                          input logic [63:0] tm, input bit expect_out);
    int nl;
    logic [127:0] d;
    nl = (int'(len) + 15) / 16;
    sq[port].push_back({vld, len, 16'(port * 256 + nl), tm});
    for (int i = 0; i < nl; i++) begin
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      dq[port].push_back(d);
      if (expect_out) exp_q.push_back({i == 0, i == nl - 1, 2'(port), len, tm, d});
    end
    refresh();
  endtask

  always @(posedge sys_clk) begin
    logic [95:0]  ts;
    logic [127:0] td;
    #1;
    if (sys_rst_n) begin
      for (int i = 0; i < PN; i++) begin
        if (stat_pop_s[i] && sq[i].size() != 0) begin ts = sq[i].pop_front(); stat_pops++; end
        if (data_pop_s[i] && dq[i].size() != 0) begin td = dq[i].pop_front(); data_pops++; end
      end
    end
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    refresh();
  end

  // ---------------- monitor ----------------
  always @(negedge sys_clk) begin
    stat_pop_s = stat_rd;
    data_pop_s = data_rd;
    if (sys_rst_n) begin
      if ((stat_rd | data_rd) != '0) begin
        n_cmp++;
        if ($countones(stat_rd | data_rd) != 1 || (stat_rd & stat_empty) != '0 ||
            (data_rd & data_empty) != '0) begin
          n_err++;
          $display("FAIL pop_check: stat_rd=%b data_rd=%b stat_empty=%b data_empty=%b, want one pop on a non-empty FIFO",
                   stat_rd, data_rd, stat_empty, data_empty);
        end
      end
      if (prev_hold) begin
        n_cmp++;
        if (!out_valid || out_data !== prev_data) begin
          n_err++;
          $display("FAIL hold: valid=%b data=%h, want valid=1 data=%h", out_valid, out_data, prev_data);
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      if (out_valid && out_ready)
        obs_q.push_back({out_sop, out_eop, out_port, out_len, out_time, out_data});
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic wait_done(input string name, input int budget);
    int c;
    bit done;
    c = 0;
    done = 1'b0;
    while (!done && c < budget) begin
      @(negedge sys_clk);
      c++;
      done = all_empty() && dbg_state == 2'd0 && !out_valid;
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL %s_timeout: not idle after %0d cycles, want idle", name, budget);
    end
  endtask

  task automatic reset_pulse();
    @(posedge sys_clk); #2;
    sys_rst_n = 1'b0;
    clear_all();
    repeat (2) @(posedge sys_clk);
    #2 sys_rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    sys_rst_n = 1'b0;
    ready_mode = 0;
    sq[2].push_back({1'b1, 15'd16, 16'd0, 64'd0});
    refresh();
    #2;
    n_cmp++;
    if ({out_valid, out_sop, out_eop, out_port, out_len} !== '0) begin
      n_err++;
      $display("FAIL reset_ctl: got %b, want 0", {out_valid, out_sop, out_eop, out_port, out_len});
    end
    n_cmp++;
    if (out_data !== '0 || out_time !== '0) begin
      n_err++;
      $display("FAIL reset_data: data=%h time=%h, want 0", out_data, out_time);
    end
    n_cmp++;
    if (drop_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL reset_drop: got %0d, want 0", drop_cnt);
    end
    n_cmp++;
    if ({stat_rd, data_rd} !== '0 || dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL reset_pops: stat_rd=%b data_rd=%b state=%0d, want 0/0/0", stat_rd, data_rd, dbg_state);
    end
    clear_all();
    repeat (2) @(posedge sys_clk);
    #2 sys_rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(posedge sys_clk); #2;
    stat_pops = 0; data_pops = 0;
    push_pkt(1, 1'b1, 15'd40, 64'h0000_1111_2222_3333, 1'b1);
    wait_done("single", 200);
    n_cmp++;
    if (obs_q.size() != 3 || exp_q.size() != 3) begin
      n_err++;
      $display("FAIL single_count: got %0d lines, want 3", obs_q.size());
    end
    for (int i = 0; i < 3 && i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL single_line%0d: got %h, want %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (stat_pops != 1 || data_pops != 3 || drop_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL single_pops: stat=%0d data=%0d drop=%0d, want 1/3/0", stat_pops, data_pops, drop_cnt);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_rr_order();
    reset_pulse();
    @(posedge sys_clk); #2;
    stat_pops = 0; data_pops = 0;
    for (int p = 0; p < PN; p++) push_pkt(p, 1'b1, 15'd16, 64'(p + 100), 1'b1);
    wait_done("rr", 300);
    n_cmp++;
    if (obs_q.size() != 4) begin
      n_err++;
      $display("FAIL rr_count: got %0d lines, want 4", obs_q.size());
    end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL rr_line%0d: got port %0d %h, want port %0d %h", i,
                 obs_q[i][208:207], obs_q[i], exp_q[i][208:207], exp_q[i]);
      end
    end
    n_cmp++;
    if (stat_pops != 4 || data_pops != 4) begin
      n_err++;
      $display("FAIL rr_pops: stat=%0d data=%0d, want 4/4", stat_pops, data_pops);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_drop();
    @(posedge sys_clk); #2;
    stat_pops = 0; data_pops = 0;
    push_pkt(2, 1'b0, 15'd100, 64'hBAD, 1'b0);
    push_pkt(3, 1'b1, 15'd16, 64'h3333, 1'b1);
    wait_done("drop", 300);
    n_cmp++;
    if (obs_q.size() != 1) begin
      n_err++;
      $display("FAIL drop_count: got %0d lines, want 1", obs_q.size());
    end else begin
      n_cmp++;
      if (obs_q[0] !== exp_q[0]) begin
        n_err++;
        $display("FAIL drop_next: got %h, want %h", obs_q[0], exp_q[0]);
      end
    end
    n_cmp++;
    if (stat_pops != 2 || data_pops != 8 || drop_cnt !== 32'd1) begin
      n_err++;
      $display("FAIL drop_pops: stat=%0d data=%0d drop=%0d, want 2/8/1", stat_pops, data_pops, drop_cnt);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_ready_toggle();
    logic [127:0] d [4];
    @(posedge sys_clk); #2;
    stat_pops = 0; data_pops = 0;
    ready_mode = 1;
    sq[0].push_back({1'b1, 15'd64, 16'h0004, 64'h7777});
    for (int i = 0; i < 4; i++) begin
      d[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
      exp_q.push_back({i == 0, i == 3, 2'd0, 15'd64, 64'h7777, d[i]});
    end
    dq[0].push_back(d[0]);
    dq[0].push_back(d[1]);
    refresh();
    repeat (8) @(posedge sys_clk);
    #2;
    dq[0].push_back(d[2]);
    dq[0].push_back(d[3]);
    refresh();
    wait_done("toggle", 300);
    ready_mode = 0;
    n_cmp++;
    if (obs_q.size() != 4) begin
      n_err++;
      $display("FAIL toggle_count: got %0d lines, want 4", obs_q.size());
    end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL toggle_line%0d: got %h, want %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (stat_pops != 1 || data_pops != 4) begin
      n_err++;
      $display("FAIL toggle_pops: stat=%0d data=%0d, want 1/4", stat_pops, data_pops);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_zero_len();
    @(posedge sys_clk); #2;
    stat_pops = 0; data_pops = 0;
    push_pkt(0, 1'b1, 15'd0, 64'h0, 1'b0);
    @(negedge sys_clk);
    n_cmp++;
    if (stat_rd !== 4'b0001 || data_rd !== 4'b0000) begin
      n_err++;
      $display("FAIL zero_grant: stat_rd=%b data_rd=%b, want 0001/0000", stat_rd, data_rd);
    end
    @(negedge sys_clk);
    n_cmp++;
    if (dbg_state !== 2'd2 || data_rd !== 4'b0000) begin
      n_err++;
      $display("FAIL zero_drop: state=%0d data_rd=%b, want 2/0000", dbg_state, data_rd);
    end
    @(negedge sys_clk);
    n_cmp++;
    if (dbg_state !== 2'd0 || drop_cnt !== 32'd2 || data_pops != 0 || stat_pops != 1) begin
      n_err++;
      $display("FAIL zero_done: state=%0d drop=%0d dpops=%0d spops=%0d, want 0/2/0/1",
               dbg_state, drop_cnt, data_pops, stat_pops);
    end
  endtask

  task automatic test_reset_mid();
    int c;
    @(posedge sys_clk); #2;
    push_pkt(1, 1'b1, 15'd80, 64'h5555, 1'b0);
    c = 0;
    do begin
      @(negedge sys_clk);
      c++;
    end while (!(out_valid && !out_sop) && c < 50);
    n_cmp++;
    if (c >= 50) begin
      n_err++;
      $display("FAIL mid_reach: line 2 not seen in 50 cycles, want seen");
    end
    #1 sys_rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, out_sop, out_eop, out_port, out_len, out_time, out_data, drop_cnt,
         stat_rd, data_rd, dbg_state} !== '0) begin
      n_err++;
      $display("FAIL mid_reset: valid=%b data=%h len=%0d drop=%0d pops=%b/%b state=%0d, want all 0",
               out_valid, out_data, out_len, drop_cnt, stat_rd, data_rd, dbg_state);
    end
    clear_all();
    @(posedge sys_clk);
    #2 sys_rst_n = 1'b1;
    push_pkt(0, 1'b1, 15'd16, 64'hA0, 1'b1);
    push_pkt(3, 1'b1, 15'd16, 64'hA3, 1'b1);
    wait_done("mid", 200);
    n_cmp++;
    if (obs_q.size() != 2) begin
      n_err++;
      $display("FAIL mid_count: got %0d lines, want 2", obs_q.size());
    end
    for (int i = 0; i < 2 && i < obs_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL mid_order%0d: got port %0d, want port %0d", i, obs_q[i][208:207], exp_q[i][208:207]);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    out_ready = 1'b1;
    ready_mode = 0;
    prev_hold = 1'b0;
    stat_pop_s = '0;
    data_pop_s = '0;
    refresh();
    test_reset();
    test_single();
    test_rr_order();
    test_drop();
    test_ready_toggle();
    test_zero_len();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
